board_update_scheduler: RTL

Owns the 8x8 chess board state and schedules every write to it so the board only changes during vertical blanking, so a frame never shows a half-moved piece. Game logic pushes moves through a valid/ready queue. The pixel generator reads square contents combinationally through a dedicated read port. The block runs on the VGA pixel clock and takes the controller's blanking status as its frame-timing reference.

---
 rtl/chess_pkg.sv | 37 +++
 rtl/move_fifo.sv | 52 +++++
 rtl/board_update_scheduler.sv | 94 +++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared types and constants for the chess board update scheduler:
// piece encoding, the start position, scheduler states and queued-move layout.
package chess_pkg;

  typedef logic [3:0] piece_t;

  localparam piece_t EMPTY  = 4'h0;
  localparam piece_t PAWN   = 4'h1;
  localparam piece_t KNIGHT = 4'h2;
  localparam piece_t BISHOP = 4'h3;
  localparam piece_t ROOK   = 4'h4;
  localparam piece_t QUEEN  = 4'h5;
  localparam piece_t KING   = 4'h6;
  localparam piece_t BLACK  = 4'h8;

  // Square index = row*8 + col, row 0 is black's back rank at the top.
  localparam piece_t START_BOARD [0:63] = '{
    BLACK|ROOK, BLACK|KNIGHT, BLACK|BISHOP, BLACK|QUEEN,
    BLACK|KING, BLACK|BISHOP, BLACK|KNIGHT, BLACK|ROOK,
    BLACK|PAWN, BLACK|PAWN, BLACK|PAWN, BLACK|PAWN,
    BLACK|PAWN, BLACK|PAWN, BLACK|PAWN, BLACK|PAWN,
    EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY,
    PAWN, PAWN, PAWN, PAWN, PAWN, PAWN, PAWN, PAWN,
    ROOK, KNIGHT, BISHOP, QUEEN, KING, BISHOP, KNIGHT, ROOK
  };

  typedef enum logic [1:0] {IDLE, DST, SRC, LOAD} sched_state_t;

  typedef struct packed {
    logic [5:0] from;
    logic [5:0] to;
  } move_t;

endpackage

// File: rtl/move_fifo.sv
// Small FIFO of pending moves with a combinational head and a one-cycle flush.
module move_fifo
  import chess_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  move_t         din,
  output logic          full,
  output logic [CW-1:0] count,
  output move_t         head
);

  move_t         mem_q [0:DEPTH-1];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count_q != '0);
  assign count   = count_q;
  assign head    = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only count/pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/board_update_scheduler.sv
// Owns the 8x8 board and applies queued moves or a start-position reload
// only while vblank is high, so a displayed frame never shows a partial move.
module board_update_scheduler
  import chess_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       mv_valid,
  input  logic [5:0] mv_from,
  input  logic [5:0] mv_to,
  output logic       mv_ready,
  input  logic       new_game,
  input  logic [5:0] rd_sq,
  output logic [3:0] rd_piece,
  output logic [2:0] pending,
  output logic       applied
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_t  state_q;
  logic          ng_pend_q;
  logic          applied_q;
  piece_t        board_q [0:63];

  logic          full, push, pop, flush, null_move;
  logic [CW-1:0] count;
  move_t         head;

  assign mv_ready  = ~full & ~ng_pend_q;
  assign push      = mv_valid & mv_ready;
  assign null_move = (head.from == head.to);
  assign pop       = (state_q == SRC) | ((state_q == DST) & null_move);
  assign flush     = (state_q == LOAD);
  assign pending   = 3'(count);
  assign applied   = applied_q;
  assign rd_piece  = board_q[rd_sq];

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (vgaclk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ('{from: mv_from, to: mv_to}),
    .full  (full),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ng_pend_q <= 1'b0;
      applied_q <= 1'b0;
      board_q   <= START_BOARD;
    end else begin
      applied_q <= 1'b0;
      if (new_game) ng_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (vblank && ng_pend_q)         state_q <= LOAD;
          else if (vblank && count != '0)  state_q <= DST;
        end
        DST: begin
          // A null move is retired here; SRC would otherwise erase the piece.
          if (null_move) begin
            applied_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            board_q[head.to] <= board_q[head.from];
            state_q          <= SRC;
          end
        end
        SRC: begin
          board_q[head.from] <= EMPTY;
          applied_q          <= 1'b1;
          state_q            <= IDLE;
        end
        LOAD: begin
          board_q   <= START_BOARD;
          ng_pend_q <= 1'b0;
          applied_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
